instr_prefetch_buffer: RTL and testbench

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

---
 rtl/instr_prefetch_buffer.sv | 129 ++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: fetches sequential words into a small FIFO ahead of decode.
// One memory request outstanding at a time; redirects flush the FIFO and may orphan a request.
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCTargetE,
  input  logic        PCSrcE,
  input  logic        StallF,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0]   NOP_INSTR  = 32'h00000013;
  localparam logic [31:0]   RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

  logic [1:0]    r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_stale_pc;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_started;

  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic [1:0]    w_state_next;
  logic [31:0]   w_target;

  assign w_target = PCTargetE & 32'hFFFF_FFFC;
  assign w_push   = (r_state == S_REQ) && ImemAck && !PCSrcE;
  assign w_pop    = ValidF && !StallF && !PCSrcE;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_next = r_count - CW'(1);
  end

  // A redirect that catches a request in flight must still wait out its ack (DROP).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!PCSrcE && r_started && (r_count < FULL_COUNT))
          w_state_next = S_REQ;
      end
      S_REQ: begin
        if (PCSrcE)
          w_state_next = ImemAck ? S_IDLE : S_DROP;
        else if (ImemAck)
          w_state_next = (w_count_next < FULL_COUNT) ? S_REQ : S_IDLE;
      end
      S_DROP: begin
        if (ImemAck)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC_W;
      r_stale_pc <= RESET_PC_W;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_started  <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_state   <= w_state_next;
      if (PCSrcE) begin
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_fetch_pc <= w_target;
        if ((r_state == S_REQ) && !ImemAck)
          r_stale_pc <= r_fetch_pc;
      end else begin
        r_count <= w_count_next;
        if (w_push) begin
          r_wr_ptr   <= r_wr_ptr + PW'(1);
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
      r_instr_mem[r_wr_ptr] <= ImemData;
    end
  end

  assign ImemReq  = (r_state == S_REQ) || (r_state == S_DROP);
  assign ImemAddr = (r_state == S_DROP) ? r_stale_pc : r_fetch_pc;
  assign ValidF   = (r_count != '0);
  assign InstrF   = ValidF ? r_instr_mem[r_rd_ptr] : NOP_INSTR;
  assign PCF      = ValidF ? r_pc_mem[r_rd_ptr] : 32'h00000000;
  assign PCPlus4F = PCF + 32'd4;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: directed cycle table, async reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_instr_prefetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        PCSrcE = 1'b0;
  logic        StallF = 1'b0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck = 1'b0;
  logic [31:0] ImemData = '0;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        ValidF;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h00000000)) dut (
    .clk(clk), .rst(rst), .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .StallF(StallF),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        stall, ack, pcsrc;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pcf;
  } vec_t;

  vec_t tab[22];

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic vec_t mk(input logic s, input logic a, input logic p, input logic [31:0] t,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.ack = a; v.pcsrc = p; v.tgt = t;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pcf = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic req, input logic [31:0] addr, input logic valid,
                               input logic [31:0] pcf);
    chk("ImemReq", 32'(ImemReq), 32'(req));
    if (req) chk("ImemAddr", ImemAddr, addr);
    chk("ValidF", 32'(ValidF), 32'(valid));
    chk("PCF", PCF, pcf);
    chk("PCPlus4F", PCPlus4F, pcf + 32'd4);
    chk("InstrF", InstrF, valid ? memfn(pcf) : NOP);
  endtask

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] m_fetch, m_stale;
  int          m_out;  // 0 no request, 1 live request, 2 orphaned request

  initial begin
    int lat, wcnt, pre_size;
    logic s, a, p, req_pre;
    logic [31:0] t;

    //               stall ack pcsrc tgt        req addr        valid pcf
    tab[0]  = mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    tab[1]  = mk(0, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    tab[2]  = mk(0, 1, 0, 32'h0,   1, 32'h4,   1, 32'h0);
    tab[3]  = mk(0, 1, 0, 32'h0,   1, 32'h8,   1, 32'h4);
    tab[4]  = mk(0, 1, 0, 32'h0,   1, 32'hC,   1, 32'h8);
    tab[5]  = mk(0, 0, 0, 32'h0,   1, 32'hC,   0, 32'h0);
    tab[6]  = mk(0, 1, 0, 32'h0,   1, 32'h10,  1, 32'hC);
    tab[7]  = mk(0, 1, 1, 32'h43,  0, 32'h40,  0, 32'h0);
    tab[8]  = mk(0, 0, 0, 32'h0,   1, 32'h40,  0, 32'h0);
    tab[9]  = mk(0, 1, 0, 32'h0,   1, 32'h44,  1, 32'h40);
    tab[10] = mk(1, 1, 0, 32'h0,   1, 32'h48,  1, 32'h40);
    tab[11] = mk(1, 1, 0, 32'h0,   1, 32'h4C,  1, 32'h40);
    tab[12] = mk(1, 1, 0, 32'h0,   0, 32'h50,  1, 32'h40);
    tab[13] = mk(1, 0, 0, 32'h0,   0, 32'h50,  1, 32'h40);
    tab[14] = mk(0, 0, 0, 32'h0,   0, 32'h50,  1, 32'h44);
    tab[15] = mk(0, 0, 0, 32'h0,   1, 32'h50,  1, 32'h48);
    tab[16] = mk(0, 1, 0, 32'h0,   1, 32'h54,  1, 32'h4C);
    tab[17] = mk(1, 0, 1, 32'h100, 1, 32'h54,  0, 32'h0);
    tab[18] = mk(0, 0, 1, 32'h200, 1, 32'h54,  0, 32'h0);
    tab[19] = mk(0, 1, 0, 32'h0,   0, 32'h200, 0, 32'h0);
    tab[20] = mk(0, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0);
    tab[21] = mk(0, 1, 0, 32'h0,   1, 32'h204, 1, 32'h200);

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs(1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;

    // Directed table: inputs for the next edge, outputs expected after it
    for (int i = 0; i < 22; i++) begin
      StallF    = tab[i].stall;
      ImemAck   = tab[i].ack;
      PCSrcE    = tab[i].pcsrc;
      PCTargetE = tab[i].tgt;
      ImemData  = memfn(ImemAddr);
      @(posedge clk);
      @(negedge clk);
      check_outputs(tab[i].exp_req, tab[i].exp_addr, tab[i].exp_valid, tab[i].exp_pcf);
    end

    // Buffer up to 3 entries, then assert reset mid-request with an ack pending
    for (int i = 0; i < 2; i++) begin
      StallF = 1'b1; ImemAck = 1'b1; PCSrcE = 1'b0; ImemData = memfn(ImemAddr);
      @(posedge clk);
      @(negedge clk);
    end
    chk("buffered_pcf", PCF, 32'h200);
    ImemAck = 1'b1;
    ImemData = memfn(ImemAddr);
    #2 rst = 1'b0;
    #1 check_outputs(1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_outputs(1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1; ImemAck = 1'b0; StallF = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs(1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_outputs(1'b1, 32'h0, 1'b0, 32'h0);

    // Randomized traffic against the model
    mq.delete();
    m_fetch = 32'h0; m_stale = 32'h0; m_out = 1;
    lat = $urandom_range(0, 3); wcnt = 0;
    for (int c = 0; c < 800; c++) begin
      check_outputs(m_out != 0, (m_out == 2) ? m_stale : m_fetch, mq.size() != 0,
                    (mq.size() != 0) ? mq[0] : 32'h0);
      StallF    = ($urandom_range(0, 1) == 0);
      PCSrcE    = ($urandom_range(0, 19) == 0);
      PCTargetE = $urandom % 4096;
      ImemAck   = ImemReq && (wcnt >= lat);
      ImemData  = memfn(ImemAddr);
      s = StallF; a = ImemAck; p = PCSrcE; t = PCTargetE; req_pre = ImemReq;
      pre_size = mq.size();
      @(posedge clk);
      if (p) begin
        mq.delete();
        if (m_out == 1 && !a) begin
          m_out = 2;
          m_stale = m_fetch;
        end else if (!(m_out == 2 && !a)) begin
          m_out = 0;
        end
        m_fetch = t & ~32'h3;
      end else begin
        if (pre_size != 0 && !s) void'(mq.pop_front());
        case (m_out)
          0: if (pre_size < DEPTH) m_out = 1;
          1: if (a) begin
               mq.push_back(m_fetch);
               m_fetch = m_fetch + 32'd4;
               if (mq.size() >= DEPTH) m_out = 0;
             end
          default: if (a) m_out = 0;
        endcase
      end
      if (a) begin
        wcnt = 0;
        lat = $urandom_range(0, 3);
      end else if (req_pre) begin
        wcnt++;
      end else begin
        wcnt = 0;
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
